// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: FP op sequencer, one op in flight (FDIV support under `FP_DIV_EN).
// Latency: accept to WB is LAT+1 cycles, FDIV DivDone+1 or DIV_TIMEOUT+1.
// Backpressure: Stall holds the core from accept through EXEC; Flush aborts without a write.
module fp_issue_ctrl #(
    parameter int ADD_LAT     = 2,
    parameter int MUL_LAT     = 3,
    parameter int CMP_LAT     = 1,
    parameter int DIV_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       FPValid,
    input  logic [2:0] FPOp,
    input  logic [4:0] FPRd,
    input  logic       Flush,
    input  logic       DivDone,
    output logic       FUStart,
    output logic [2:0] FUOp,
    output logic [4:0] WbRd,
    output logic       FPRegWrite,
    output logic       Stall,
    output logic       Busy,
    output logic       IllegalOp,
    output logic       Timeout
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [2:0] OP_FDIV  = 3'b011;
    localparam logic [5:0] DIV_LOAD = 6'(DIV_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       accept;
    logic       fustart_nxt;
    logic       set_timeout;
    logic       illegal_wb;

    function automatic logic [5:0] lat_load(input logic [2:0] op);
        case (op)
            3'b000, 3'b001: lat_load = 6'(ADD_LAT - 1);
            3'b010:         lat_load = 6'(MUL_LAT - 1);
            default:        lat_load = 6'(CMP_LAT - 1);
        endcase
    endfunction

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        accept      = 1'b0;
        fustart_nxt = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (FPValid && !Flush) begin
                    accept = 1'b1;
                    if (FPOp == OP_FDIV) begin
`ifdef FP_DIV_EN
                        state_nxt   = EXEC;
                        cnt_nxt     = DIV_LOAD;
                        fustart_nxt = 1'b1;
`else
                        // Unsupported divide skips straight to WB to raise IllegalOp.
                        state_nxt   = WB;
                        cnt_nxt     = 6'd0;
`endif
                    end else begin
                        state_nxt   = EXEC;
                        cnt_nxt     = lat_load(FPOp);
                        fustart_nxt = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (Flush) begin
                    state_nxt = IDLE;
                end
`ifdef FP_DIV_EN
                else if (FUOp == OP_FDIV) begin
                    // A result arriving on the last budget cycle still counts as done.
                    if (DivDone) begin
                        state_nxt = WB;
                    end else if (cnt == 6'd0) begin
                        state_nxt   = WB;
                        set_timeout = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                    end
                end
`endif
                else if (cnt == 6'd0) begin
                    state_nxt = WB;
                end else begin
                    cnt_nxt = cnt - 6'd1;
                end
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            FUOp    <= 3'd0;
            WbRd    <= 5'd0;
            Timeout <= 1'b0;
            FUStart <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            FUStart <= fustart_nxt;
            if (accept) begin
                FUOp    <= FPOp;
                WbRd    <= FPRd;
                Timeout <= 1'b0;
            end else if (set_timeout) begin
                Timeout <= 1'b1;
            end
        end
    end

`ifdef FP_DIV_EN
    assign illegal_wb = 1'b0;
`else
    assign illegal_wb = (FUOp == OP_FDIV);
    logic [6:0] div_unused;
    assign div_unused = {DivDone, DIV_LOAD};
`endif

    // Timeout is cleared on accept, so in WB it describes the op being retired.
    assign FPRegWrite = (state == WB) && !Flush && !Timeout && !illegal_wb;
    assign IllegalOp  = (state == WB) && illegal_wb;
    assign Stall      = ((state == IDLE) && FPValid && !Flush) || (state == EXEC);
    assign Busy       = (state != IDLE);

endmodule
